alu_writeback_seq: RTL and testbench

- Stage directly downstream of the ALU.
- Latches the 64-bit ALU result into the Z register pair on the `z_in` strobe and derives zero/negative condition flags.
- Sequences writeback to the register file over a valid/ready port:
  - mul/div: two transfers, LO then HI.
  - 32-bit ops: one transfer to the destination register.
- Frees the datapath control unit from hand-stepping Zlow/Zhigh/LOin/HIin cycles.

---
 rtl/alu_writeback_seq.sv | 156 +++++++++++++++
 tb/tb_alu_writeback_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_seq.sv
// alu_writeback_seq: sits directly after the ALU. Captures the 64-bit
// result into the Z register pair, derives zero/negative flags, and
// sequences the register-file writeback (one transfer for 32-bit ops,
// LO then HI for mul/div) over a valid/ready port.
//
// Writeback handshake: a transfer happens on a rising edge where
// wb_valid && wb_ready. Once wb_valid is raised, wb_dest and wb_data hold
// stable until that transfer, and wb_valid only drops after a transfer
// (or on clear).
module alu_writeback_seq #(
    parameter int          DATA_W = 32,
    parameter logic [4:0]  LO_IDX = 5'd16,
    parameter logic [4:0]  HI_IDX = 5'd17
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  z_in,
    input  logic [4:0]            op_code,
    input  logic [2*DATA_W-1:0]   c,
    input  logic [3:0]            dest_sel,
    input  logic                  wb_ready,
    output logic                  wb_valid,
    output logic [4:0]            wb_dest,
    output logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     z_low,
    output logic [DATA_W-1:0]     z_high,
    output logic                  flag_zero,
    output logic                  flag_neg,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REG = 3'd1,
        WR_LO  = 3'd2,
        WR_HI  = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;

    state_t state;
    state_t cap_next;
    logic   cap_zero;
    logic   cap_neg;

    assign state_dbg = state;

    // Decode the opcode presented with z_in: where the sequence goes and
    // which part of the result the flags look at (mul uses all 64 bits).
    always_comb begin
        cap_next = FIN;
        cap_zero = (c[DATA_W-1:0] == '0);
        cap_neg  = c[DATA_W-1];
        if (op_code == OP_MUL) begin
            cap_zero = (c == '0);
            cap_neg  = c[2*DATA_W-1];
        end
        if (op_code == OP_MUL || op_code == OP_DIV) begin
            cap_next = WR_LO;
        end else if ((op_code >= 5'b00011 && op_code <= 5'b01110) ||
                     op_code == 5'b10001 || op_code == 5'b10010) begin
            cap_next = WR_REG;
        end else begin
            cap_next = FIN;
        end
    end

    // Sequencer: capture in IDLE, step through writebacks on handshakes,
    // pulse done from FIN. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
            z_low     <= '0;
            z_high    <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            // A capture request outside IDLE is dropped but remembered.
            if (z_in && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (z_in) begin
                        z_low     <= c[DATA_W-1:0];
                        z_high    <= c[2*DATA_W-1:DATA_W];
                        flag_zero <= cap_zero;
                        flag_neg  <= cap_neg;
                        busy      <= 1'b1;
                        state     <= cap_next;
                        case (cap_next)
                            WR_LO: begin
                                wb_valid <= 1'b1;
                                wb_dest  <= LO_IDX;
                                wb_data  <= c[DATA_W-1:0];
                            end
                            WR_REG: begin
                                wb_valid <= 1'b1;
                                wb_dest  <= {1'b0, dest_sel};
                                wb_data  <= c[DATA_W-1:0];
                            end
                            default: begin
                                // Capture-only op: straight to completion.
                                wb_valid <= 1'b0;
                                done     <= 1'b1;
                            end
                        endcase
                    end
                end
                WR_REG: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                WR_LO: begin
                    if (wb_ready) begin
                        wb_dest <= HI_IDX;
                        wb_data <= z_high;
                        state   <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Bench for alu_writeback_seq: directed scenarios plus randomized ops,
// checked against a transaction-level model (expected transfer list,
// flags and completion latency derived from the opcode rules).
module tb_alu_writeback_seq;

    logic        clk;
    logic        clear;
    logic        z_in;
    logic [4:0]  op_code;
    logic [63:0] c;
    logic [3:0]  dest_sel;
    logic        wb_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [31:0] z_low;
    logic [31:0] z_high;
    logic        flag_zero;
    logic        flag_neg;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    // expected transfers: {dest[4:0], data[31:0]}
    logic [36:0] exp_q[$];

    alu_writeback_seq dut (
        .clk(clk), .clear(clear), .z_in(z_in), .op_code(op_code), .c(c),
        .dest_sel(dest_sel), .wb_ready(wb_ready), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .z_low(z_low), .z_high(z_high),
        .flag_zero(flag_zero), .flag_neg(flag_neg), .busy(busy), .done(done),
        .overrun(overrun), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; z_in = 1'b0; wb_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, wb_valid, 0);
        check({tag, "_dest"}, wb_dest, 0);
        check({tag, "_data"}, wb_data, 0);
        check({tag, "_zlow"}, z_low, 0);
        check({tag, "_zhigh"}, z_high, 0);
        check({tag, "_flags"}, {flag_zero, flag_neg}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Reference model: what writebacks an op produces.
    task automatic build_expect(input logic [4:0] op, input logic [63:0] cv, input logic [3:0] dst);
        exp_q.delete();
        if (op == 5'd16 || op == 5'd15) begin
            exp_q.push_back({5'd16, cv[31:0]});
            exp_q.push_back({5'd17, cv[63:32]});
        end else if ((op >= 5'd3 && op <= 5'd14) || op == 5'd17 || op == 5'd18) begin
            exp_q.push_back({1'b0, dst, cv[31:0]});
        end
    endtask

    // Driver: issue one op from a negedge and follow it to completion.
    // mode 0: ready high, 1: random ready, 2: ready low for 3 cycles then high.
    task automatic run_op(input logic [4:0] op, input logic [63:0] cv,
                          input logic [3:0] dst, input int mode);
        int  n_xfer;
        int  valid_cycles;
        bit  got_done;
        bit  rdy;
        logic exp_zero;
        logic exp_neg;
        build_expect(op, cv, dst);
        n_xfer = exp_q.size();
        exp_zero = (op == 5'd16) ? (cv == 64'd0) : (cv[31:0] == 32'd0);
        exp_neg  = (op == 5'd16) ? cv[63] : cv[31];
        valid_cycles = 0;
        got_done = 1'b0;
        z_in = 1'b1; op_code = op; c = cv; dest_sel = dst; wb_ready = 1'b0;
        @(negedge clk);
        z_in = 1'b0;
        c = {$urandom, $urandom};
        for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
            check("busy_active", busy, 1);
            if (done) begin
                got_done = 1'b1;
                check("xfers_left", exp_q.size(), 0);
                check("valid_at_done", wb_valid, 0);
                if (mode == 0) check("latency", cyc, n_xfer + 1);
                if (mode == 2) check("stall_valid_cycles", valid_cycles, n_xfer + 3);
                check("flag_zero", flag_zero, exp_zero);
                check("flag_neg", flag_neg, exp_neg);
                check("z_low", z_low, cv[31:0]);
                check("z_high", z_high, cv[63:32]);
            end else begin
                if (wb_valid) begin
                    valid_cycles++;
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", wb_valid, 0);
                    end else begin
                        check("wb_dest", wb_dest, exp_q[0][36:32]);
                        check("wb_data", wb_data, exp_q[0][31:0]);
                    end
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = 1'($urandom_range(0, 1));
                    default: rdy = (cyc > 3);
                endcase
                wb_ready = rdy;
                if (wb_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
                @(negedge clk);
            end
        end
        wb_ready = 1'b0;
        if (!got_done) begin
            check("timeout", 0, 1);
            do_clear();
        end else begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end
    endtask

    initial begin
        clear = 1'b1; z_in = 1'b0; op_code = '0; c = '0; dest_sel = '0; wb_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        check_all_zero("reset");

        // reset in the middle of a mul writeback
        z_in = 1'b1; op_code = 5'd16; c = 64'hDEAD_BEEF_1234_5678; dest_sel = 4'd1;
        @(negedge clk);
        z_in = 1'b0;
        check("mid_lo_valid", wb_valid, 1);
        check("mid_lo_dest", wb_dest, 16);
        z_in = 1'b1;
        @(negedge clk);
        z_in = 1'b0;
        check("mid_overrun", overrun, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all_zero("midclr");
        run_op(5'd3, 64'd9, 4'd6, 0);

        // add
        run_op(5'd3, 64'h0000_0000_0000_0005, 4'd3, 0);
        // mul with backpressure
        run_op(5'd16, 64'hFFFF_FFFF_FFFF_FFF6, 4'd0, 2);
        // div
        run_op(5'd15, {32'd2, 32'd7}, 4'd0, 0);
        // sub, low word zero
        run_op(5'd4, 64'h1234_5678_0000_0000, 4'd9, 0);
        // ld: capture only
        run_op(5'd0, 64'h0000_0000_8000_0001, 4'd2, 0);
        check("no_overrun_yet", overrun, 0);

        // overrun during WR_REG
        z_in = 1'b1; op_code = 5'd3; c = 64'h0000_0000_0000_00AA; dest_sel = 4'd2;
        @(negedge clk);
        c = 64'h0000_0000_0000_00BB; dest_sel = 4'd5;
        @(negedge clk);
        z_in = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_zlow", z_low, 32'hAA);
        check("ovr_wbdata", wb_data, 32'hAA);
        check("ovr_wbdest", wb_dest, 2);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        check("ovr_done", done, 1);
        @(negedge clk);
        check("ovr_idle", busy, 0);
        check("ovr_sticky", overrun, 1);
        do_clear();
        check("ovr_cleared", overrun, 0);

        // randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [63:0] cv;
            logic [4:0]  op;
            cv = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) cv[31:0] = 32'd0;
            if ($urandom_range(0, 7) == 0) cv = 64'd0;
            op = 5'($urandom_range(0, 31));
            run_op(op, cv, 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        end
        check("final_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
